// File: rtl/cpu_pkg.sv
// cpu_pkg: shared decode constants, scoreboard types and opcode classing
package cpu_pkg;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_LD  = 4'h9;
    localparam logic [3:0] OP_ST  = 4'hA;
    localparam logic [3:0] OP_BEQ = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam int OP_LSB = 0;
    localparam int DR_LSB = 4;
    localparam int SR_LSB = 7;
    localparam int TR_LSB = 10;
    localparam logic [1:0] FWD_REG  = 2'd0;
    localparam logic [1:0] FWD_EXMA = 2'd1;
    localparam logic [1:0] FWD_MAWB = 2'd2;
    localparam logic [1:0] FWD_WB   = 2'd3;
    typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH} state_t;
    typedef struct packed {
        logic rd_sr;
        logic rd_tr;
        logic wr_dr;
        logic is_ld;
    } op_class_t;
    typedef struct packed {
        logic       valid;
        logic       wr;
        logic       ld;
        logic [2:0] dr;
    } slot_t;
    function automatic op_class_t op_class(input logic [3:0] op);
        op_class_t c;
        c.rd_sr = !op[3] || (op >= OP_LD && op < OP_JMP);
        c.rd_tr = !op[3] || op == OP_ST || op == OP_BEQ;
        c.wr_dr = !op[3] || op == OP_LDI || op == OP_LD;
        c.is_ld = op == OP_LD;
        return c;
    endfunction
endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: youngest-first forwarding source select for one EX operand
module fwd_sel
    import cpu_pkg::*;
(
    input  logic       rd,
    input  logic [2:0] r,
    input  slot_t      ex,
    input  slot_t      ma,
    input  slot_t      wb,
    output logic [1:0] sel
);
    logic hit_ex, hit_ma, hit_wb, unused_ld;
    assign hit_ex = ex.valid && ex.wr && ex.dr == r;
    assign hit_ma = ma.valid && ma.wr && ma.dr == r;
    assign hit_wb = wb.valid && wb.wr && wb.dr == r;
    assign unused_ld = ex.ld ^ ma.ld ^ wb.ld;
    always_comb sel = !rd ? FWD_REG : hit_ex ? FWD_EXMA : hit_ma ? FWD_MAWB : hit_wb ? FWD_WB : FWD_REG;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control, EX forwarding selects and perf counters
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      dc_instr,
    input  logic             dc_valid,
    input  logic             br_taken,
    output logic             pc_hold,
    output logic             ifdc_hold,
    output logic             ifdc_flush,
    output logic             ex_bubble,
    output logic [1:0]       fwd_sr_sel,
    output logic [1:0]       fwd_tr_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    op_class_t  cls;
    state_t     state;
    slot_t      ex_s, ma_s, wb_s;
    logic [2:0] dr, sr, tr, unused_hi;
    logic [1:0] sr_sel, tr_sel;
    logic       rd_sr, rd_tr, load_use;
    assign cls       = op_class(dc_instr[OP_LSB +: 4]);
    assign dr        = dc_instr[DR_LSB +: 3];
    assign sr        = dc_instr[SR_LSB +: 3];
    assign tr        = dc_instr[TR_LSB +: 3];
    assign unused_hi = dc_instr[15:13];
    assign rd_sr     = dc_valid && cls.rd_sr;
    assign rd_tr     = dc_valid && cls.rd_tr;
    // A load in EX only has data at MA/WB, so a same-register reader must wait one cycle
    assign load_use  = state != S_FLUSH && ex_s.valid && ex_s.ld &&
                       ((rd_sr && sr == ex_s.dr) || (rd_tr && tr == ex_s.dr));
    assign ifdc_flush = br_taken;
    assign ex_bubble  = br_taken || load_use;
    assign pc_hold    = !br_taken && load_use;
    assign ifdc_hold  = pc_hold;
    fwd_sel u_sr (.rd(rd_sr), .r(sr), .ex(ex_s), .ma(ma_s), .wb(wb_s), .sel(sr_sel));
    fwd_sel u_tr (.rd(rd_tr), .r(tr), .ex(ex_s), .ma(ma_s), .wb(wb_s), .sel(tr_sel));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_RUN;
            ex_s       <= '0;
            ma_s       <= '0;
            wb_s       <= '0;
            fwd_sr_sel <= FWD_REG;
            fwd_tr_sel <= FWD_REG;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            state      <= br_taken ? S_FLUSH : load_use ? S_STALL : S_RUN;
            ex_s       <= '{valid: dc_valid && !ex_bubble, wr: cls.wr_dr, ld: cls.is_ld, dr: dr};
            ma_s       <= ex_s;
            wb_s       <= ma_s;
            fwd_sr_sel <= ex_bubble ? FWD_REG : sr_sel;
            fwd_tr_sel <= ex_bubble ? FWD_REG : tr_sel;
            if (pc_hold && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
            if (br_taken && !(&flush_cnt))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with a queued-expectation monitor
module tb_hazard_ctrl;
    localparam int CW = 3;
    localparam int C_STALL = 13;
    localparam int C_FLUSH = 3;
    logic          clk = 0;
    logic          rst_n = 0;
    logic          dc_valid = 0;
    logic          br_taken = 0;
    logic [15:0]   dc_instr = '0;
    logic          pc_hold, ifdc_hold, ifdc_flush, ex_bubble;
    logic [1:0]    fwd_sr_sel, fwd_tr_sel;
    logic [CW-1:0] stall_cnt, flush_cnt;
    int            cyc = 0;
    int            n_chk = 0;
    int            n_fail = 0;
    typedef struct {
        string name;
        int    cyc;
        int    kind;
        int    val;
    } exp_t;
    exp_t q[$];
    exp_t keep[$];

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .dc_instr(dc_instr), .dc_valid(dc_valid),
        .br_taken(br_taken), .pc_hold(pc_hold), .ifdc_hold(ifdc_hold),
        .ifdc_flush(ifdc_flush), .ex_bubble(ex_bubble), .fwd_sr_sel(fwd_sr_sel),
        .fwd_tr_sel(fwd_tr_sel), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] ins(input int op, input int dr, input int sr, input int tr);
        return {3'b000, 3'(tr), 3'(sr), 3'(dr), 4'(op)};
    endfunction

    function automatic int actual(input int kind);
        case (kind)
            0:       return int'({pc_hold, ifdc_hold, ifdc_flush, ex_bubble});
            1:       return int'(fwd_sr_sel);
            2:       return int'(fwd_tr_sel);
            3:       return int'(stall_cnt);
            default: return int'(flush_cnt);
        endcase
    endfunction

    task automatic expect_at(input string name, input int c, input int kind, input int val);
        exp_t e;
        e.name = name;
        e.cyc  = c;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endtask

    // Controls are checked in the issue cycle, selects one cycle later
    task automatic step(input string name, input logic [15:0] i, input logic v, input logic br,
                        input int ctl, input int sr, input int tr);
        @(posedge clk);
        #1;
        dc_instr = i;
        dc_valid = v;
        br_taken = br;
        expect_at({name, "_ctl"}, cyc, 0, ctl);
        expect_at({name, "_sr"}, cyc + 1, 1, sr);
        expect_at({name, "_tr"}, cyc + 1, 2, tr);
    endtask

    task automatic cnt(input string name, input int s, input int f);
        expect_at({name, "_stall_cnt"}, cyc, 3, s);
        expect_at({name, "_flush_cnt"}, cyc, 4, f);
    endtask

    task automatic idle(input int n);
        repeat (n) step("idle", 16'h0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic reset_checks(input string name);
        for (int k = 0; k < 5; k++) expect_at(name, cyc, k, 0);
    endtask

    always @(negedge clk) begin
        keep.delete();
        foreach (q[k]) begin
            if (q[k].cyc <= cyc) begin
                n_chk++;
                if (q[k].cyc < cyc || actual(q[k].kind) != q[k].val) begin
                    n_fail++;
                    $display("FAIL %s cyc %0d: got %0d want %0d (due cyc %0d)",
                             q[k].name, cyc, actual(q[k].kind), q[k].val, q[k].cyc);
                end
            end else keep.push_back(q[k]);
        end
        q = keep;
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset_checks("reset");
        @(negedge clk);
        #1;
        rst_n = 1;
        // ALU -> ALU forwarding from EX
        step("t1_a", ins(0, 1, 2, 3), 1, 0, 0, 0, 0);
        step("t1_b", ins(1, 4, 1, 5), 1, 0, 0, 1, 0);
        idle(3);
        // load-use: one stall, then MA/WB forwarding
        step("t2_ld", ins(9, 2, 0, 0), 1, 0, 0, 0, 0);
        step("t2_use", ins(0, 6, 2, 2), 1, 0, C_STALL, 0, 0);
        step("t2_held", ins(0, 6, 2, 2), 1, 0, 0, 2, 2);
        cnt("t2", 1, 0);
        idle(3);
        // WB retire forwarding and its expiry
        step("t3_p", ins(0, 3, 0, 0), 1, 0, 0, 0, 0);
        step("t3_i1", ins(0, 5, 4, 4), 1, 0, 0, 0, 0);
        step("t3_i2", ins(0, 6, 4, 4), 1, 0, 0, 0, 0);
        step("t3_wb", ins(0, 1, 3, 3), 1, 0, 0, 3, 3);
        step("t3_old", ins(0, 2, 3, 0), 1, 0, 0, 0, 0);
        idle(3);
        // taken branch overrides a load-use stall
        step("t4_ld", ins(9, 4, 0, 0), 1, 0, 0, 0, 0);
        step("t4_br", ins(0, 1, 4, 4), 1, 1, C_FLUSH, 0, 0);
        step("t4_rec", 16'h0, 0, 0, 0, 0, 0);
        cnt("t4", 1, 1);
        idle(3);
        // youngest producer wins
        step("t5_alu", ins(0, 7, 0, 0), 1, 0, 0, 0, 0);
        step("t5_ldi", ins(8, 7, 0, 0), 1, 0, 0, 0, 0);
        step("t5_st", ins(10, 0, 1, 7), 1, 0, 0, 0, 1);
        idle(3);
        // reset in the STALL cycle clears everything
        step("t6_p", ins(0, 5, 0, 0), 1, 0, 0, 0, 0);
        step("t6_ld", ins(9, 6, 5, 0), 1, 0, 0, 1, 0);
        step("t6_use", ins(0, 2, 6, 0), 1, 0, C_STALL, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 0;
        dc_valid = 0;
        dc_instr = '0;
        reset_checks("t6_rst");
        @(negedge clk);
        #1;
        rst_n = 1;
        step("t6_reuse", ins(0, 2, 6, 0), 1, 0, 0, 0, 0);
        idle(3);
        // counters saturate at all-ones
        for (int n = 0; n < 9; n++) begin
            step("t7_ld", ins(9, 1, 0, 0), 1, 0, 0, 0, 0);
            step("t7_use", ins(0, 2, 1, 0), 1, 0, C_STALL, 0, 0);
            step("t7_held", ins(0, 2, 1, 0), 1, 0, 0, 2, 0);
        end
        idle(1);
        cnt("t7_stall_sat", 7, 0);
        for (int n = 0; n < 9; n++) step("t7_br", 16'h0, 0, 1, C_FLUSH, 0, 0);
        idle(1);
        cnt("t7_flush_sat", 7, 7);
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 16-bit five-stage core (IF, DC, EX, MA, WB). It watches the instruction sitting in DC and keeps a three-slot scoreboard of destination registers in flight in EX, MA and WB. From these it generates the stall, bubble and flush controls for the stage registers, plus registered operand-forwarding selects for the EX operand muxes. It also keeps saturating stall and flush counters for performance debug.

## Interface
- `CNT_W`, default 16: width of the performance counters.
- `clk` input, 1: rising-edge clock shared with all stage registers.
- `rst_n` input, 1: asynchronous, active-low reset.
- `dc_instr` input, 16: instruction currently in DC. Fields: op [3:0], dr [6:4], sr [9:7], tr [12:10].
- `dc_valid` input, 1: DC holds a real instruction, not a bubble.
- `br_taken` input, 1: branch or jump in EX resolved taken this cycle.
- `pc_hold` output, 1: hold the PC.
- `ifdc_hold` output, 1: hold the IF/DC register.
- `ifdc_flush` output, 1: load a bubble into IF/DC.
- `ex_bubble` output, 1: load a bubble into DC/EX instead of DC contents.
- `fwd_sr_sel` output, 2: EX sr-operand source. 0 = regfile, 1 = EX/MA result, 2 = MA/WB result, 3 = WB retire latch.
- `fwd_tr_sel` output, 2: same encoding, for the tr operand.
- `stall_cnt` output, CNT_W: load-use stall cycles, saturating.
- `flush_cnt` output, CNT_W: taken-branch flushes, saturating.

## Operation
Opcode classes, decoded from `op`:
- 0x0–0x7 ALU: reads sr and tr, writes dr.
- 0x8 LDI: writes dr only.
- 0x9 LD: reads sr, writes dr; data is ready only at MA/WB.
- 0xA ST: reads sr and tr.
- 0xB BEQ: reads sr and tr.
- 0xC JMP: reads nothing.
- 0xD–0xF: NOP, no reads or writes.

Scoreboard:
- Slots ex, ma, wb each hold {valid, wr, ld, dr}.
- Each cycle: wb ← ma, ma ← ex, ex ← DC info.
- When `ex_bubble` is 1, ex ← invalid instead.
- Any register number 0–7 is a real register; there is no hard-wired zero.

Hazard rules:
- Load-use: `dc_valid`, and slot ex is a valid LD, and DC reads a register equal to ex.dr.
- Forwarding, evaluated per operand with youngest-first priority:
  - match in slot ex → 1;
  - else match in slot ma → 2;
  - else match in slot wb → 3;
  - else 0.
- A match requires slot valid and wr set. Operands DC does not read get select 0.

FSM states:
- RUN. Transitions:
  - `br_taken` → FLUSH.
  - Load-use (and no `br_taken`) → STALL.
  - Otherwise stay in RUN.
- STALL, lasts exactly 1 cycle, then RUN.
  - `br_taken` during STALL still causes a flush. Go to FLUSH instead.
- FLUSH, lasts 1 cycle, then RUN. It only marks the recovery cycle: `dc_valid` is 0 there, so no hazard can fire.

Outputs (combinational from state, scoreboard, `dc_instr` and `br_taken`):
- `br_taken`: `ifdc_flush` = 1, `ex_bubble` = 1, `pc_hold` = 0. Highest priority; a load-use stall in the same cycle is discarded.
- Load-use without `br_taken`: `pc_hold` = `ifdc_hold` = `ex_bubble` = 1.
- Otherwise all four controls are 0.

Forward selects:
- Registered, so they are valid during the cycle the instruction sits in EX.
- Latched on the edge where DC advances, i.e. `ex_bubble` = 0.
- Forced to 0 on a bubble.

Counters:
- `stall_cnt` increments on each load-use cycle.
- `flush_cnt` increments on each `br_taken` cycle.
- Both hold at all-ones.

## Timing
- Reset (asynchronous): state = RUN, all slots invalid, `fwd_*_sel` = 0, both counters = 0.
  - Control outputs are 0, except `ifdc_flush`/`ex_bubble` follow `br_taken`. Both inputs must be 0 during reset.
  - Reset mid-stall or mid-flush returns to RUN with the scoreboard empty.
- Latency:
  - Hazard controls: 0 cycles (same cycle as `dc_instr`).
  - Forward selects: 1 cycle.
  - Scoreboard: updates on every edge. There is no hold of scoreboard slots; bubbles shift through.
- A load-use stall is exactly 1 cycle. The held instruction then forwards with select 2.
- Back-to-back LD→LD→use: each load-use fires independently. A second stall is allowed.
- `br_taken` while DC holds a load-use consumer: flush wins, `stall_cnt` is unchanged.

## Structure
- Package `cpu_pkg` holds:
  - opcode constants (OP_LDI, OP_LD, OP_ST, OP_BEQ, OP_JMP);
  - the field slice positions;
  - the FWD_REG/FWD_EXMA/FWD_MAWB/FWD_WB encodings;
  - the state enum;
  - function `op_class(op)` → {rd_sr, rd_tr, wr_dr, is_ld}.
- One sub-module, `fwd_sel`: a comparator for one operand (slots in, 2-bit select out), instantiated twice.

## Test plan
- ALU r1←r2,r3 followed by ALU r4←r1,r5 → `fwd_sr_sel` = 1 in the second instruction's EX cycle, no stall.
- LD r2 followed immediately by ALU r6←r2,r2 → one cycle with `pc_hold`, `ifdc_hold` and `ex_bubble` = 1. Then both selects = 2; `stall_cnt` = 1.
- Producer to r3, two independent instructions, then a reader of r3 → select 3. With one more independent instruction → select 0.
- `br_taken` in the same cycle as a load-use condition → `ifdc_flush` = 1, `pc_hold` = 0, `flush_cnt` +1, `stall_cnt` unchanged.
- ST reading r7, while a LDI r7 is in EX and an ALU r7 is in MA → `fwd_tr_sel` = 1 (youngest wins).
- Assert `rst_n` = 0 mid-STALL → selects and counters are 0 immediately; the next reader of a previously in-flight register gets select 0.
